// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles a framed byte stream into 32-bit words, writes them from address 0,
// then releases the pipeline. Optional feature macro: LOADER_CHECKSUM_EN (adds XOR checksum byte and CHECK state).
module instr_mem_loader #(
  parameter int         NB_INSTR           = 32,
  parameter int         N_ADDR             = 32,
  parameter int         LOG2_N_INSMEM_ADDR = $clog2(N_ADDR),
  parameter logic [7:0] RELOAD_CMD         = 8'hA5
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_wr_en,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_wr_addr,
  output logic [NB_INSTR-1:0]           o_wr_data,
  output logic                          o_pipe_reset,
  output logic                          o_pipe_valid,
  output logic                          o_done,
  output logic                          o_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 3'd2,
`endif
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                          r_state;
  logic [7:0]                      r_words_left;
  logic [1:0]                      r_byte_cnt;
  logic [NB_INSTR-9:0]             r_asm;
  logic [LOG2_N_INSMEM_ADDR-1:0]   r_word_addr;
  logic                            r_wr_en;
  logic [LOG2_N_INSMEM_ADDR-1:0]   r_wr_addr;
  logic [NB_INSTR-1:0]             r_wr_data;
  logic                            r_pipe_reset;
  logic                            r_pipe_valid;
  logic                            r_done;
  logic                            r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                      r_xor;
`endif

  logic                w_count_ok;
  logic                w_reload;
  logic [NB_INSTR-1:0] w_word;

  assign w_count_ok = (i_rx_data != 8'd0) && (32'(i_rx_data) <= 32'(N_ADDR));
  // The reload command only acts once the image is finished (RUN) or rejected (ERROR); inside LOAD it is data.
  assign w_reload   = i_rx_valid && (i_rx_data == RELOAD_CMD) &&
                      ((r_state == S_RUN) || (r_state == S_ERROR));
  assign w_word     = {r_asm, i_rx_data};

  always_ff @(posedge i_clock) begin
    if (i_reset || w_reload) begin
      r_state      <= S_IDLE;
      r_words_left <= 8'd0;
      r_byte_cnt   <= 2'd0;
      r_asm        <= {(NB_INSTR-8){1'b0}};
      r_word_addr  <= {LOG2_N_INSMEM_ADDR{1'b0}};
      r_wr_en      <= 1'b0;
      r_wr_addr    <= {LOG2_N_INSMEM_ADDR{1'b0}};
      r_wr_data    <= {NB_INSTR{1'b0}};
      r_pipe_reset <= 1'b1;
      r_pipe_valid <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor        <= 8'd0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            if (w_count_ok) begin
              r_words_left <= i_rx_data;
              r_byte_cnt   <= 2'd0;
              r_word_addr  <= {LOG2_N_INSMEM_ADDR{1'b0}};
`ifdef LOADER_CHECKSUM_EN
              r_xor        <= i_rx_data;
`endif
              r_state      <= S_LOAD;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end
          end
        end
        S_LOAD: begin
          if (i_rx_valid) begin
            r_asm      <= w_word[NB_INSTR-9:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ i_rx_data;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_wr_en      <= 1'b1;
              r_wr_addr    <= r_word_addr;
              r_wr_data    <= w_word;
              r_word_addr  <= r_word_addr + LOG2_N_INSMEM_ADDR'(1);
              r_words_left <= r_words_left - 8'd1;
              if (r_words_left == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                r_state <= S_CHECK;
`else
                r_state <= S_START;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (i_rx_valid) begin
            if (i_rx_data == r_xor) begin
              r_state <= S_START;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end
          end
        end
`endif
        // Pipeline reset stays high through this cycle; outputs switch together as RUN begins.
        S_START: begin
          r_pipe_reset <= 1'b0;
          r_pipe_valid <= 1'b1;
          r_done       <= 1'b1;
          r_state      <= S_RUN;
        end
        S_RUN, S_ERROR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_pipe_reset = r_pipe_reset;
  assign o_pipe_valid = r_pipe_valid;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a cycle table, fixed frames and randomized frames checked
// against a frame-level model (expected write list and end state computed from the frame bytes).
module tb_instr_mem_loader;
  localparam int N_ADDR = 32;
  localparam int AW     = $clog2(N_ADDR);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          pipe_reset, pipe_valid, done, error;

  always #5 clk = ~clk;

  instr_mem_loader #(.NB_INSTR(32), .N_ADDR(N_ADDR)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_pipe_reset(pipe_reset), .o_pipe_valid(pipe_valid), .o_done(done), .o_error(error));

  int n_vec = 0;
  int n_err = 0;
  logic [AW+31:0] wq[$];
  logic [31:0]    fr_words[0:255];

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        cd;
    logic        pr, pv, dn, er;
  } vec_t;
  vec_t tbl[$];

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic pr, input logic pv, input logic dn, input logic er);
    chk({nm, ".pipe_reset"}, 32'(pipe_reset), 32'(pr));
    chk({nm, ".pipe_valid"}, 32'(pipe_valid), 32'(pv));
    chk({nm, ".done"},       32'(done),       32'(dn));
    chk({nm, ".error"},      32'(error),      32'(er));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".wr_en"},   32'(wr_en),   32'd0);
    chk({nm, ".wr_addr"}, 32'(wr_addr), 32'd0);
    chk({nm, ".wr_data"}, wr_data,      32'd0);
    chk_outs(nm, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive(input logic [7:0] b, input logic v);
    @(negedge clk);
    rx_data  = b;
    rx_valid = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    drive(b, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic we, input logic [31:0] wd,
                              input logic cd, input logic pr, input logic pv, input logic dn, input logic er);
    vec_t r;
    r.d = d; r.v = v; r.we = we; r.a = 32'd0; r.wd = wd; r.cd = cd;
    r.pr = pr; r.pv = pv; r.dn = dn; r.er = er;
    return r;
  endfunction

  // Model: a frame of n words from fr_words; legal n writes words 0..n-1 in order, then RUN (or ERROR on bad checksum).
  task automatic do_frame(input int n, input bit corrupt, input int maxgap);
    logic [7:0] x;
    logic [7:0] b;
    bit legal;
    wq.delete();
    legal = (n >= 1) && (n <= N_ADDR);
    x = 8'(n);
    send(8'(n), $urandom_range(maxgap, 0));
    if (!legal) begin
      idle(1);
      chk_outs("badcnt", 1'b1, 1'b0, 1'b0, 1'b1);
      send(8'h3C, 0);
      idle(2);
      chk_outs("badcnt.hold", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("badcnt.nowrite", 32'(wq.size()), 32'd0);
      send(8'hA5, 0);
      idle(1);
      chk_outs("badcnt.reload", 1'b1, 1'b0, 1'b0, 1'b0);
      return;
    end
    for (int w = 0; w < n; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = fr_words[w][8*k +: 8];
        x = x ^ b;
        send(b, $urandom_range(maxgap, 0));
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send(x ^ {7'd0, corrupt}, $urandom_range(maxgap, 0));
`endif
    idle(1);
    chk_outs("frame.start", 1'b1, 1'b0, 1'b0, corrupt);
    idle(1);
    if (corrupt) chk_outs("frame.err", 1'b1, 1'b0, 1'b0, 1'b1);
    else         chk_outs("frame.run", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("frame.nwrites", 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk("frame.addr", 32'(wq[i][AW+31:32]), 32'(i));
      chk("frame.data", wq[i][31:0], fr_words[i]);
    end
    send(8'h3C, $urandom_range(2, 0));
    idle(1);
    if (corrupt) chk_outs("frame.junk", 1'b1, 1'b0, 1'b0, 1'b1);
    else         chk_outs("frame.junk", 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'hA5, $urandom_range(2, 0));
    idle(1);
    chk_outs("frame.reload", 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    bit cor;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    // Per-cycle table: row outputs are those registered by the edge that samples the row's input.
    tbl.push_back(mk(8'h01, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(8'hAC, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(8'h01, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(8'h04, 1'b1, 1'b1, 32'hAC010004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef LOADER_CHECKSUM_EN
    tbl.push_back(mk(8'hA8, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(8'h3C, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(8'hA5, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(8'h3C, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(8'hA5, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(8'h21, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(8'h20, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(8'hA5, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(8'h20, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rx_data = tbl[i].d; rx_valid = tbl[i].v;
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d].wr_en", i), 32'(wr_en), 32'(tbl[i].we));
      if (tbl[i].cd) begin
        chk($sformatf("tbl[%0d].wr_addr", i), 32'(wr_addr), tbl[i].a);
        chk($sformatf("tbl[%0d].wr_data", i), wr_data, tbl[i].wd);
      end
      chk_outs($sformatf("tbl[%0d]", i), tbl[i].pr, tbl[i].pv, tbl[i].dn, tbl[i].er);
    end
    pulse_reset();
    chk_reset_vals("reset2");

    // Abort after 6 bytes of a 2-word frame, then a fresh frame must load from address 0.
    send(8'h02, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0); send(8'h55, 0);
    pulse_reset();
    chk_reset_vals("midload");
    fr_words[0] = 32'hDEADBEEF; fr_words[1] = 32'h0BADCAFE;
    do_frame(2, 1'b0, 0);

    fr_words[0] = 32'h20010005; fr_words[1] = 32'h00000000;
    do_frame(2, 1'b0, 0);
`ifdef LOADER_CHECKSUM_EN
    do_frame(2, 1'b1, 0);
`endif
    for (int i = 0; i < N_ADDR; i++) fr_words[i] = $urandom;
    do_frame(N_ADDR, 1'b0, 0);
    do_frame(N_ADDR + 1, 1'b0, 0);
    do_frame(0, 1'b0, 0);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(7, 0) == 0) n = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, N_ADDR + 1);
      else                           n = $urandom_range(N_ADDR, 1);
      for (int i = 0; i < 256; i++) fr_words[i] = $urandom;
      cor = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cor = ($urandom_range(3, 0) == 0);
`endif
      do_frame(n, cor, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writer side of the pipeline's instruction memory. Takes a byte stream from the host receiver and assembles 32-bit instructions. Writes them sequentially into instruction memory from address 0. While loading, it holds the pipeline in reset; when the image is complete, it releases the pipeline by driving its `i_reset`/`i_valid` inputs.

## Interface
Parameters:
- `NB_INSTR`, 32, instruction width; must be 32 (four bytes per word).
- `N_ADDR`, 32, instruction memory depth in words; also the maximum legal word count.
- `LOG2_N_INSMEM_ADDR`, clogb2(N_ADDR), write address width.
- `RELOAD_CMD`, 8'hA5, byte that returns the block from RUN/ERROR to IDLE.

Ports:
- `i_clock` in 1: single clock, all logic on rising edge.
- `i_reset` in 1: synchronous, active-high.
- `i_rx_data` in 8: received byte.
- `i_rx_valid` in 1: `i_rx_data` valid this cycle. A single-cycle strobe; each high cycle is one byte.
- `o_wr_en` in → out 1: instruction memory write strobe.
- `o_wr_addr` out LOG2_N_INSMEM_ADDR: write word address.
- `o_wr_data` out NB_INSTR: write data.
- `o_pipe_reset` out 1: drives pipeline `i_reset`.
- `o_pipe_valid` out 1: drives pipeline `i_valid`.
- `o_done` out 1: image loaded, pipeline running.
- `o_error` out 1: framing or checksum error latched.

## Operation
Frame format:
- Byte 0: word count N, legal range 1..N_ADDR.
- Then N×4 data bytes, MSB first per word.
- Then one checksum byte (only when `LOADER_CHECKSUM_EN` is defined).

States:
- IDLE
  - Waits for the count byte.
  - N==0 or N>N_ADDR → ERROR.
  - Otherwise latch N, clear byte counter, word address and running XOR → LOAD.
- LOAD
  - Shift each accepted byte into a 32-bit assembly register.
  - On the 4th byte of a word, issue the write.
  - When the write of word N-1 issues → CHECK (macro on) or START (macro off).
- CHECK
  - On the next byte, compare it to the running XOR.
  - Match → START; mismatch → ERROR.
- START: one cycle with `o_pipe_reset`=1, then → RUN. `i_rx_valid` is ignored in this state.
- RUN
  - `o_pipe_reset`=0, `o_pipe_valid`=1, `o_done`=1.
  - Byte == RELOAD_CMD → IDLE. All other bytes are ignored.
- ERROR
  - `o_error`=1, pipeline held in reset.
  - RELOAD_CMD → IDLE and clears `o_error`. Other bytes are ignored.

Outputs by state:
- `o_pipe_reset` is 1 in every state except RUN.
- `o_pipe_valid` is 1 only in RUN.

Arithmetic:
- Running XOR covers the count byte and all data bytes, 8-bit.
- Word address increments by 1 after each write. It never wraps, because N≤N_ADDR is enforced.
- Byte counter is 2 bits and wraps per word.

## Timing
Reset values (and values after IDLE entry):
- `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0.
- `o_pipe_reset`=1, `o_pipe_valid`=0.
- `o_done`=0, `o_error`=0.
- State = IDLE.

Write timing:
- `o_wr_en` pulses high for exactly one cycle, the cycle after the 4th byte of a word is sampled.
- `o_wr_addr`/`o_wr_data` are registered and stable during that pulse.

Release timing:
- Macro off: last data byte sampled at edge k → write pulse in cycle k+1 → START in cycle k+1 → RUN from cycle k+2.
- Macro on: checksum byte sampled at edge c → START in c+1 → RUN from c+2.

Boundary conditions:
- Back-to-back `i_rx_valid` on consecutive cycles must be accepted without loss.
- `i_reset` mid-load aborts immediately: outputs return to reset values and memory contents already written are left as-is.
- RELOAD_CMD inside LOAD is treated as data, not as a command.

## Configuration
- `LOADER_CHECKSUM_EN` defined: CHECK state and XOR accumulator are built in. The frame ends with the checksum byte, and a mismatch leads to ERROR.
- Not defined: no CHECK state and no accumulator. START follows the last word's write directly, and `o_error` can only be raised by an illegal count.

## Test plan
- Macro on, bytes 02,20,01,00,05,00,00,00,00,26 → writes (0,0x20010005), (1,0x00000000); `o_pipe_reset` falls and `o_pipe_valid`=`o_done`=1 two cycles after the 26 byte.
- Same frame with checksum 27 → no release; `o_error`=1 and `o_pipe_reset`=1; then A5 → IDLE with `o_error`=0.
- Count byte 00, and separately count 21 (33) with N_ADDR=32 → ERROR, and `o_wr_en` never asserted.
- Macro off, 01,AC,01,00,04 sent on consecutive cycles → single write (0,0xAC010004); RUN two cycles after the last byte.
- `i_reset` pulsed after 6 bytes of a 2-word frame → all outputs at reset values next cycle; a fresh full frame then loads correctly from address 0.
- In RUN, byte 3C ignored; byte A5 → `o_pipe_valid`=0, `o_pipe_reset`=1, `o_done`=0 the next cycle.
